// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86-64 PIPE stall/bubble control, IDLE/RUN/DRAIN/HALTED lifecycle and saturating perf counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mp_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;
    state_t           r_state;
    logic [2:0]       r_final_stat;
    logic [CNT_W-1:0] r_cyc, r_ret, r_lu, r_mp;
    logic w_lu, w_rp, w_mp, w_xm, w_xw, w_busy, w_act, w_drain, w_halt;
    function automatic logic exc(input logic [2:0] s);
        return s == 3'b010 || s == 3'b011 || s == 3'b100;
    endfunction
    assign w_lu    = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
                     (E_dstM == d_srcA || E_dstM == d_srcB);
    assign w_rp    = D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
    assign w_mp    = E_icode == 4'h7 && !e_Cnd;
    assign w_xm    = exc(m_stat);
    assign w_xw    = exc(W_stat);
    assign w_busy  = r_state == S_RUN || r_state == S_DRAIN;
    // Reset forces IDLE-valued controls combinationally, whatever the state register holds.
    assign w_act   = !rst && w_busy;
    assign w_drain = !rst && r_state == S_DRAIN;
    assign w_halt  = !rst && r_state == S_HALT;
    assign F_stall    = w_act ? (w_lu | w_rp) : 1'b1;
    assign D_stall    = w_act ? w_lu : w_halt;
    assign D_bubble   = w_act ? (w_mp | (w_rp & ~w_lu)) : ~w_halt;
    assign E_bubble   = w_act ? (w_mp | w_lu) : 1'b1;
    assign M_bubble   = w_act ? (w_xm | w_xw | w_drain) : 1'b1;
    assign W_stall    = w_act ? w_xw : w_halt;
    assign set_cc     = w_act && !w_drain && E_icode == 4'h6 && !w_xm && !w_xw;
    assign halted     = w_halt;
    assign final_stat = r_final_stat;
    assign cyc_cnt    = r_cyc;
    assign ret_cnt    = r_ret;
    assign lu_cnt     = r_lu;
    assign mp_cnt     = r_mp;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_final_stat <= 3'b001;
            r_cyc        <= '0;
            r_ret        <= '0;
            r_lu         <= '0;
            r_mp         <= '0;
        end else begin
            if (r_state == S_IDLE && start)
                r_state <= S_RUN;
            else if (w_busy && w_xw) begin
                r_state      <= S_HALT;
                r_final_stat <= W_stat;
            end else if (r_state == S_RUN && w_xm)
                r_state <= S_DRAIN;
            if (w_busy) begin
                r_cyc <= r_cyc + CNT_W'(~&r_cyc);
                r_ret <= r_ret + CNT_W'((w_rp & ~w_lu) & ~&r_ret);
                r_lu  <= r_lu + CNT_W'(w_lu & ~&r_lu);
                r_mp  <= r_mp + CNT_W'(w_mp & ~&r_mp);
            end
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl; a spec-level model predicts every cycle plus directed test-plan checks.
module tb_pipe_ctrl;
    logic clk = 0, rst = 1, start = 0, e_Cnd = 0;
    logic [3:0] D_icode = 0, d_srcA = 4'hF, d_srcB = 4'hF, E_icode = 0, E_dstM = 4'hF, M_icode = 0;
    logic [2:0] m_stat = 1, W_stat = 1;
    logic F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted;
    logic [2:0] final_stat;
    logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt;
    logic F2, Ds2, Ws2, Db2, Eb2, Mb2, cc2, h2;
    logic [2:0] fs2;
    logic [3:0] cyc2, ret2, lu2, mp2;
    int n_chk = 0, n_err = 0;
    typedef struct packed {
        logic [7:0]  c;
        logic [2:0]  fs;
        logic [31:0] cy, rt, lu, mp;
    } exp_t;
    exp_t sb[$];
    int m_st = 0;
    logic [2:0] m_fs = 1;
    logic [31:0] m_cy = 0, m_rt = 0, m_lu = 0, m_mp = 0;
    logic [7:0] g_c;
    logic [2:0] g_fs;
    logic [31:0] g_cy, g_rt, g_lu, g_mp;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
        .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .set_cc(set_cc),
        .halted(halted), .final_stat(final_stat), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
        .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
        .W_stat(W_stat), .F_stall(F2), .D_stall(Ds2), .W_stall(Ws2),
        .D_bubble(Db2), .E_bubble(Eb2), .M_bubble(Mb2), .set_cc(cc2),
        .halted(h2), .final_stat(fs2), .cyc_cnt(cyc2), .ret_cnt(ret2),
        .lu_cnt(lu2), .mp_cnt(mp2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exc(input logic [2:0] s);
        return s == 3'd2 || s == 3'd3 || s == 3'd4;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v, input logic inc);
        return (inc && v != 32'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    // Order of ctrl bits: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc halted.
    task automatic cyc(input logic r, input logic st, input logic [3:0] di, input logic [3:0] sa,
                       input logic [3:0] sbr, input logic [3:0] ei, input logic [3:0] edm,
                       input logic cnd, input logic [3:0] mi, input logic [2:0] ms, input logic [2:0] ws);
        logic lu, rp, mp, xm, xw, act, dr;
        exp_t e, p;
        rst = r; start = st; D_icode = di; d_srcA = sa; d_srcB = sbr; E_icode = ei;
        E_dstM = edm; e_Cnd = cnd; M_icode = mi; m_stat = ms; W_stat = ws;
        lu = (ei == 4'h5 || ei == 4'hB) && edm != 4'hF && (edm == sa || edm == sbr);
        rp = di == 4'h9 || ei == 4'h9 || mi == 4'h9;
        mp = ei == 4'h7 && !cnd;
        xm = exc(ms);
        xw = exc(ws);
        act = !r && (m_st == 1 || m_st == 2);
        dr = !r && m_st == 2;
        if (act)
            e.c = {lu | rp, lu, mp | (rp & !lu), mp | lu, xm | xw | dr, xw,
                   ei == 4'h6 && !xm && !xw && !dr, 1'b0};
        else if (!r && m_st == 3)
            e.c = 8'b1101_1101;
        else
            e.c = 8'b1011_1000;
        e.fs = m_fs; e.cy = m_cy; e.rt = m_rt; e.lu = m_lu; e.mp = m_mp;
        sb.push_back(e);
        @(negedge clk);
        g_c = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};
        g_fs = final_stat; g_cy = cyc_cnt; g_rt = ret_cnt; g_lu = lu_cnt; g_mp = mp_cnt;
        p = sb.pop_front();
        chk("ctrl", {24'd0, g_c}, {24'd0, p.c});
        chk("final_stat", {29'd0, g_fs}, {29'd0, p.fs});
        chk("cyc_cnt", g_cy, p.cy);
        chk("ret_cnt", g_rt, p.rt);
        chk("lu_cnt", g_lu, p.lu);
        chk("mp_cnt", g_mp, p.mp);
        @(posedge clk);
        if (r) begin
            m_st = 0; m_fs = 1; m_cy = 0; m_rt = 0; m_lu = 0; m_mp = 0;
        end else begin
            if (act) begin
                m_cy = sat(m_cy, 1'b1);
                m_rt = sat(m_rt, rp & !lu);
                m_lu = sat(m_lu, lu);
                m_mp = sat(m_mp, mp);
            end
            if (m_st == 0 && st) m_st = 1;
            else if (act && xw) begin m_st = 3; m_fs = ws; end
            else if (m_st == 1 && xm) m_st = 2;
        end
        #1;
    endtask

    task automatic quiet(input logic st);
        cyc(0, st, 0, 4'hF, 4'hF, 0, 4'hF, 0, 0, 3'd1, 3'd1);
    endtask

    logic [31:0] frozen;

    initial begin
        @(posedge clk); #1;
        cyc(1, 0, 0, 4'hF, 4'hF, 0, 4'hF, 0, 0, 3'd1, 3'd1);
        cyc(1, 0, 0, 4'hF, 4'hF, 0, 4'hF, 0, 0, 3'd1, 3'd1);
        chk("reset_ctrl", {24'd0, g_c}, 32'hB8);
        quiet(1);
        chk("idle_ctrl", {24'd0, g_c}, 32'hB8);
        quiet(0);
        chk("run_quiet", {24'd0, g_c}, 32'h00);
        chk("cyc_first", g_cy, 32'd0);
        quiet(0);
        chk("cyc_second", g_cy, 32'd1);
        cyc(0, 0, 0, 4'h3, 4'hF, 4'h5, 4'h3, 0, 0, 3'd1, 3'd1);
        chk("lu_ctrl", {24'd0, g_c}, 32'hD0);
        cyc(0, 0, 0, 4'h3, 4'hF, 4'h5, 4'hF, 0, 0, 3'd1, 3'd1);
        chk("lu_none_ctrl", {24'd0, g_c}, 32'h00);
        chk("lu_cnt_one", g_lu, 32'd1);
        cyc(0, 0, 4'hB, 4'h2, 4'h4, 4'hB, 4'h4, 0, 0, 3'd1, 3'd1);
        chk("lu_pop_srcB", {24'd0, g_c}, 32'hD0);
        cyc(0, 0, 4'h9, 4'hF, 4'hF, 0, 4'hF, 0, 0, 3'd1, 3'd1);
        chk("ret_d", {24'd0, g_c}, 32'hA0);
        cyc(0, 0, 0, 4'hF, 4'hF, 4'h9, 4'hF, 0, 0, 3'd1, 3'd1);
        chk("ret_e", {24'd0, g_c}, 32'hA0);
        cyc(0, 0, 0, 4'hF, 4'hF, 0, 4'hF, 0, 4'h9, 3'd1, 3'd1);
        chk("ret_m", {24'd0, g_c}, 32'hA0);
        cyc(0, 0, 4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 0, 0, 3'd1, 3'd1);
        chk("lu_and_ret", {24'd0, g_c}, 32'hD0);
        chk("ret_cnt_three", g_rt, 32'd3);
        cyc(0, 0, 0, 4'hF, 4'hF, 4'h7, 4'hF, 0, 0, 3'd1, 3'd1);
        chk("mp_ctrl", {24'd0, g_c}, 32'h30);
        cyc(0, 0, 0, 4'hF, 4'hF, 4'h7, 4'hF, 1, 0, 3'd1, 3'd1);
        chk("mp_taken", {24'd0, g_c}, 32'h00);
        chk("mp_cnt_one", g_mp, 32'd1);
        cyc(0, 0, 0, 4'hF, 4'hF, 4'h6, 4'hF, 0, 0, 3'd0, 3'd0);
        chk("opq_bub_cc", {24'd0, g_c}, 32'h02);
        for (int i = 0; i < 24; i++) begin
            cyc(0, 0, 4'(i), 4'($urandom_range(0, 15)), 4'hF, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'(i + 3), 3'd1, 3'd1);
        end
        cyc(0, 0, 0, 4'hF, 4'hF, 4'h6, 4'hF, 0, 0, 3'd3, 3'd1);
        chk("xm_ctrl", {24'd0, g_c}, 32'h08);
        cyc(0, 0, 0, 4'hF, 4'hF, 4'h6, 4'hF, 0, 0, 3'd1, 3'd3);
        chk("drain_xw", {24'd0, g_c}, 32'h0C);
        frozen = cyc_cnt;
        quiet(1);
        chk("halt_ctrl", {24'd0, g_c}, 32'hDD);
        chk("halt_stat", {29'd0, g_fs}, 32'd3);
        quiet(1);
        chk("cnt_frozen", g_cy, frozen);
        chk("halt_ignores_start", {31'd0, halted}, 32'd1);
        chk("sat_cyc4", {28'd0, cyc2}, 32'd15);
        cyc(1, 0, 0, 4'hF, 4'hF, 0, 4'hF, 0, 0, 3'd1, 3'd1);
        quiet(1);
        cyc(0, 0, 0, 4'hF, 4'hF, 0, 4'hF, 0, 0, 3'd4, 3'd1);
        quiet(0);
        chk("drain_quiet", {24'd0, g_c}, 32'h08);
        cyc(1, 0, 0, 4'hF, 4'hF, 4'h6, 4'hF, 0, 0, 3'd1, 3'd1);
        chk("rst_in_drain", {24'd0, g_c}, 32'hB8);
        quiet(0);
        chk("after_rst_ctrl", {24'd0, g_c}, 32'hB8);
        chk("after_rst_cyc", g_cy, 32'd0);
        chk("after_rst_stat", {29'd0, g_fs}, 32'd1);
        cyc(0, 0, 0, 4'hF, 4'hF, 0, 4'hF, 0, 0, 3'd2, 3'd2);
        chk("idle_ignores_xw", {24'd0, g_c}, 32'hB8);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
